// File: rtl/sync_down_timer.sv
`default_nettype none
// ============================================================================
// Module   : sync_down_timer
// Purpose  : Synchronous loadable down-counter / interval timer. Counts down
//            from a programmed value and raises a one-cycle terminal-count
//            pulse. Supports one-shot and auto-reload (periodic) operation.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   start        load load_val into count and reload register, enter RUN
//   stop         abort counting, return to IDLE, count holds
//   en           count enable; decrement/terminal actions only when high
//   auto_reload  1 = periodic, 0 = one-shot; sampled at each terminal event
//   load_val     start value, sampled on start
//   count        current count (registered)
//   tc_pulse     registered pulse: terminal event on the previous edge
//   zero         count == 0 (combinational)
//   busy         timer is in RUN (combinational)
// ============================================================================
module sync_down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc_pulse,
  output logic             zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q,     tc_d;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Priority: stop, then start, then the count action.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (stop) begin
      // Abort: count is left where it was so software can read it back.
      state_d = ST_IDLE;
    end else if (start) begin
      // Load / restart; the load cycle itself never decrements.
      count_d  = load_val;
      reload_d = load_val;
      state_d  = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (en) begin
            if (count_q != '0) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              // Terminal event: the zero count is consumed here instead of
              // decrementing, so the counter can never wrap to all-ones.
              tc_d = 1'b1;
              if (auto_reload) begin
                count_d = reload_q;
              end else begin
                state_d = ST_DONE;
              end
            end
          end
        end
        ST_IDLE, ST_DONE: begin
          // Both wait for start/stop; en has no effect here.
        end
        default: begin
          // Unreachable encoding: recover to a safe idle state.
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign count    = count_q;
  assign tc_pulse = tc_q;
  assign zero     = (count_q == '0);
  assign busy     = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_sync_down_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_down_timer
// Purpose  : Self-checking bench for sync_down_timer (WIDTH = 8). A period-
//            based reference model (enabled cycles remaining until the next
//            terminal event) is compared against the DUT after every edge,
//            plus directed scenarios with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_down_timer;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             stop;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc_pulse;
  logic             zero;
  logic             busy;

  sync_down_timer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .en          (en),
    .auto_reload (auto_reload),
    .load_val    (load_val),
    .count       (count),
    .tc_pulse    (tc_pulse),
    .zero        (zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int tc_hits  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: tracks how many enabled RUN cycles remain until the next
  // terminal event. While running the visible count is (left - 1); a one-shot
  // period is therefore load+1 enabled cycles and a reload restores the full
  // period. When not running, the last visible count is held.
  // --------------------------------------------------------------------------
  int m_left;
  int m_period;
  int m_hold;
  bit m_run;
  bit m_tc;

  function automatic int m_count();
    return m_run ? (m_left - 1) : m_hold;
  endfunction

  task automatic model_reset();
    m_left = 0; m_period = 1; m_hold = 0; m_run = 0; m_tc = 0;
  endtask

  task automatic model_edge();
    m_tc = 0;
    if (stop) begin
      if (m_run) m_hold = m_left - 1;
      m_run = 0;
    end else if (start) begin
      m_period = int'(load_val) + 1;
      m_left   = m_period;
      m_run    = 1;
    end else if (m_run && en) begin
      m_left--;
      if (m_left == 0) begin
        m_tc = 1;
        if (auto_reload) begin
          m_left = m_period;
        end else begin
          m_run  = 0;
          m_hold = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("count",    32'(count),    32'(m_count()));
    chk("tc_pulse", 32'(tc_pulse), 32'(m_tc));
    chk("zero",     32'(zero),     32'(m_count() == 0));
    chk("busy",     32'(busy),     32'(m_run));
  endtask

  task automatic drive(input logic st, input logic sp, input logic e,
                       input logic ar, input logic [WIDTH-1:0] lv);
    start = st; stop = sp; en = e; auto_reload = ar; load_val = lv;
  endtask

  // One clock: model follows the edge, DUT sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (tc_pulse) tc_hits++;
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from any clock edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_count", 32'(count),    32'd0);
    chk("rst_busy",  32'(busy),     32'd0);
    chk("rst_tc",    32'(tc_pulse), 32'd0);
    chk("rst_zero",  32'(zero),     32'd1);
    #1;
    rst = 1'b0;
  endtask

  int unsigned seq_cnt [4] = '{2, 1, 0, 0};
  int unsigned seq_tc  [4] = '{0, 0, 0, 1};

  initial begin
    int n;
    bit found;
    rst = 1'b1;
    drive(0, 0, 0, 0, '0);
    model_reset();
    #3;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_zero",  32'(zero),  32'd1);
    chk("reset_busy",  32'(busy),  32'd0);
    #4;
    rst = 1'b0;
    step();

    // ---- Reset in the middle of a run ----
    drive(1, 0, 0, 0, 8'd20); step();
    drive(0, 0, 1, 0, 8'd0);
    repeat (5) step();
    chk("midrun_count", 32'(count), 32'd15);
    async_reset();
    drive(1, 0, 0, 0, 8'd0); step();
    drive(0, 0, 1, 0, 8'd0); tc_hits = 0; step();
    chk("load0_tc_first", 32'(tc_pulse), 32'd1);

    // ---- One-shot, load 3 ----
    drive(1, 0, 0, 0, 8'd3); step();
    chk("os_load", 32'(count), 32'd3);
    drive(0, 0, 1, 0, 8'd0);
    tc_hits = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("os_seq_count", 32'(count),    seq_cnt[i]);
      chk("os_seq_tc",    32'(tc_pulse), seq_tc[i]);
    end
    chk("os_done_busy", 32'(busy), 32'd0);
    repeat (3) step();
    chk("os_tc_once", 32'(tc_hits), 32'd1);

    // ---- Auto-reload with en toggling ----
    drive(1, 0, 0, 1, 8'd2); step();
    tc_hits = 0;
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, (i % 2) == 0, 1, 8'd0);
      step();
      chk("ar_busy", 32'(busy), 32'd1);
    end
    chk("ar_tc_count", 32'(tc_hits), 32'd2);

    // ---- load 0 with auto-reload: tc every enabled cycle ----
    drive(1, 0, 0, 1, 8'd0); step();
    drive(0, 0, 1, 1, 8'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("l0ar_tc",    32'(tc_pulse), 32'd1);
      chk("l0ar_count", 32'(count),    32'd0);
    end

    // ---- Restart and priority ----
    drive(1, 0, 0, 0, 8'd10); step();
    drive(0, 0, 1, 0, 8'd0); repeat (5) step();
    chk("pri_at5", 32'(count), 32'd5);
    drive(1, 0, 1, 0, 8'd9); step();
    chk("restart_count", 32'(count),    32'd9);
    chk("restart_tc",    32'(tc_pulse), 32'd0);
    drive(0, 0, 1, 0, 8'd0); repeat (4) step();
    drive(1, 1, 1, 0, 8'd77); step();
    chk("startstop_count", 32'(count), 32'd5);
    chk("startstop_busy",  32'(busy),  32'd0);
    drive(0, 0, 1, 0, 8'd0); repeat (3) step();
    chk("idle_hold", 32'(count), 32'd5);

    // ---- Max value, one-shot: 256 enabled cycles to tc, no wrap ----
    drive(1, 0, 0, 0, 8'd255); step();
    drive(0, 0, 1, 0, 8'd0);
    n = 0; found = 0;
    while (!found && n < 300) begin
      step();
      n++;
      if (tc_pulse) found = 1;
    end
    chk("max_period", 32'(n), 32'd256);
    repeat (4) step();
    chk("max_nowrap", 32'(count), 32'd0);

    // ---- Randomized traffic against the model ----
    for (int i = 0; i < 1500; i++) begin
      logic [WIDTH-1:0] lv;
      lv = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 12));
      drive($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 70,
            ($urandom_range(0, 9) == 0) ? ~auto_reload : auto_reload, lv);
      if ($urandom_range(0, 199) == 0) async_reset();
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_down_timer.md
Name: sync_down_timer

Overview:
- Synchronous, loadable down-counter/timer. It is the counting-direction complement of the team's ripple up-counters.
- Counts down from a programmed value and flags terminal count. Supports one-shot and auto-reload (periodic) modes.
- All state changes on clk, so downstream logic sees a single-clock-domain, glitch-free count.
- Used as a programmable interval timer / clock-enable divider next to the counter library blocks.

Parameters:
- WIDTH, 8, width of count, load value and internal reload register.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  capture load_val into count and reload register; enter RUN.
- stop  input  1  abort counting; return to IDLE; count holds its value.
- en  input  1  count-enable qualifier; decrement/terminal actions occur only in cycles with en=1.
- auto_reload  input  1  1 = periodic mode, 0 = one-shot; sampled at each terminal event.
- load_val  input  WIDTH  start value, sampled on start.
- count  output  WIDTH  current count (registered).
- tc_pulse  output  1  registered one-cycle pulse; terminal event occurred on the previous edge.
- zero  output  1  combinational, count == 0.
- busy  output  1  combinational, state == RUN.

Behaviour:
- Reset (async, immediate):
  - state = IDLE
  - count = 0
  - reload_reg = 0
  - tc_pulse = 0
  - hence zero = 1, busy = 0
- States: IDLE, RUN, DONE.
- Priority each edge, highest first: stop, start, count/terminal action.
- stop=1, any state:
  - state <= IDLE
  - count holds
  - tc_pulse <= 0
  - Wins over a simultaneous start.
- start=1, stop=0, any state, including RUN (restart):
  - count <= load_val
  - reload_reg <= load_val
  - state <= RUN
  - tc_pulse <= 0
  - No decrement in this cycle.
- RUN, en=1, count != 0: count <= count - 1.
- RUN, en=1, count == 0 (terminal event):
  - tc_pulse <= 1.
  - If auto_reload=1: count <= reload_reg; stay RUN.
  - Else: count stays 0; state <= DONE.
- RUN, en=0: count, state hold.
- tc_pulse is 0 in every cycle with no terminal event, so it is never high for two consecutive cycles unless consecutive terminal events occur.
- Period: one-shot terminal event occurs after load_val+1 enabled cycles in RUN. Auto-reload period is reload_reg+1 enabled cycles.
- load_val = 0:
  - Terminal event on the first enabled RUN cycle.
  - With auto_reload=1, tc_pulse stays high every enabled cycle.
- IDLE: count holds (may be nonzero after stop); en ignored.
- DONE: count = 0; en ignored; only start or stop leave DONE.
- Decrement never wraps: the count==0 path always takes the terminal branch, never 0 -> all-ones.
- Max value: load_val = 2^WIDTH-1 is legal; period is 2^WIDTH enabled cycles.
- Reset asserted mid-count: immediate return to the reset values above; reload_reg cleared.

Test Plan:
- Reset mid-RUN (WIDTH=8, load 20, 5 enabled cycles) then assert rst -> count=0, busy=0, tc_pulse=0 immediately; reload_reg cleared (later start with load_val=0 -> tc after 1 enabled cycle).
- One-shot: load_val=3, auto_reload=0, start, en=1 continuous -> count 3,2,1,0,0; tc_pulse high exactly once on the edge after count reaches 0 with en; state DONE, busy=0, zero=1.
- Auto-reload with en gating: load_val=2, auto_reload=1, en toggling 1,0,1,... -> count decrements only on en=1 cycles; sequence 2,1,0,2,1,0; tc_pulse once per 3 enabled cycles; busy stays 1.
- load_val=0 with auto_reload=1, en=1 -> tc_pulse high every cycle; count stays 0.
- Restart and priority:
  - start mid-RUN at count=5 with load_val=9 -> count=9 next edge, no tc.
  - start+stop in the same cycle -> IDLE, count holds 5.
- Max value: WIDTH=8, load_val=255, one-shot -> tc_pulse after exactly 256 enabled cycles; count never shows 255 after reaching 0 (no wrap).
